reg_file_debug_port: RTL and testbench
======================================

// Module: reg_file_debug_port
// PURPOSE
//  Debug initiator for the 2R1W register file: drives one read port and the write port.
//  A command either dumps a contiguous register range onto a byte output stream or
//  loads a range from a byte input stream. Used by the debug/bootstrap path.
//  busy tells the core to stall and release the register file ports.
// PARAMETERS
//  DATA_W  8  register width and stream byte width
//  ADDR_W  4  register address width; the range length field is also ADDR_W bits
// PORTS
//  clk        in   1       system clock, rising edge
//  rst_n      in   1       asynchronous active-low reset
//  cmd_valid  in   1       command present
//  cmd_ready  out  1       command accepted when cmd_valid && cmd_ready
//  cmd_op     in   1       0 = DUMP, 1 = LOAD
//  cmd_addr   in   ADDR_W  first register address
//  cmd_cnt    in   ADDR_W  number of registers minus 1 (0 -> 1 reg, 15 -> 16 regs)
//  in_valid   in   1       LOAD byte present
//  in_ready   out  1       LOAD byte accepted when in_valid && in_ready
//  in_data    in   DATA_W  LOAD byte
//  out_valid  out  1       DUMP byte present
//  out_ready  in   1       DUMP byte consumed when out_valid && out_ready
//  out_data   out  DATA_W  DUMP byte
//  rf_ra      out  ADDR_W  register file read address
//  rf_rd      in   DATA_W  register file read data (combinational from rf_ra)
//  rf_wa      out  ADDR_W  register file write address
//  rf_wd      out  DATA_W  register file write data
//  rf_we      out  1       register file write enable (sampled on the next rising clk)
//  busy       out  1       high in any state other than IDLE
//  done       out  1       one-cycle pulse after the last transfer of a command
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE. Registered outputs go to 0: out_valid, out_data, done.
//   Address/count registers go to 0. rf_we=0. No write occurs while reset is asserted.
//  Reset mid-command aborts it. No done pulse is produced. A partial LOAD leaves earlier
//   writes in place. A pending DUMP byte is dropped.
//  cmd_ready = (state==IDLE). Accepting a command latches addr<=cmd_addr and rem<=cmd_cnt.
//   The next state is DUMP_RD (op 0) or LOAD (op 1).
//  DUMP_RD (1 cycle): rf_ra=addr; out_data<=rf_rd; out_valid<=1; next state DUMP_HOLD.
//  DUMP_HOLD: out_valid=1. out_data is held stable until out_ready is high.
//   On handshake with rem==0: out_valid<=0, done<=1, next state IDLE.
//   On handshake with rem!=0: out_valid<=0, addr<=addr+1, rem<=rem-1, next state DUMP_RD.
//   Throughput is 1 byte per 2 cycles at most.
//  LOAD: in_ready=1; rf_wa=addr; rf_wd=in_data; rf_we=in_valid (combinational).
//   On handshake with rem==0: done<=1, next state IDLE.
//   On handshake with rem!=0: addr<=addr+1, rem<=rem-1. Throughput is 1 byte per cycle.
//  Address arithmetic is modulo 2^ADDR_W: addr 15 + 1 -> 0. A 16-reg range from any start
//   touches every register exactly once.
//  in_ready=0 outside LOAD and rf_we=0 outside LOAD; input bytes offered then are ignored.
//  Outside DUMP_RD, rf_ra=0. Outside LOAD, rf_wa=0 and rf_wd=0.
//  done is high for exactly the cycle after the final handshake; cmd_ready is already 1 in
//   that same cycle, so a back-to-back command may be accepted there.
//  cmd_valid while busy is not accepted; the command must be held until cmd_ready is high.
// TESTING
//  1. Reset: rst_n low mid-LOAD with in_valid=1 -> rf_we=0, out_valid=0, busy=0, done=0
//     immediately; no further writes after release.
//  2. LOAD addr=3 cnt=2, bytes A1,B2,C3 every cycle -> writes R3=A1,R4=B2,R5=C3 on
//     consecutive edges; done one cycle after C3; busy for 3 cycles.
//  3. DUMP addr=14 cnt=3 with R14..R1 preloaded 0E,0F,00,01 (R0=00) -> out_data 0E,0F,00,01
//     (wrap to R0); done after 4th byte.
//  4. DUMP with out_ready low 5 cycles -> out_valid and out_data stay stable; the byte is
//     emitted once when out_ready rises.
//  5. LOAD cnt=15 with in_valid toggling randomly -> all 16 regs written exactly once,
//     in order; rf_we never high without in_valid.
//  6. New cmd_valid held during the done cycle -> accepted in that cycle; second command
//     runs with no idle gap.

Source files
------------

// File: rtl/reg_file_debug_port.sv
// reg_file_debug_port
// Debug initiator for the 2R1W register file. A command either dumps a
// contiguous register range onto the byte output stream (DUMP) or loads a
// range from the byte input stream (LOAD). busy asks the core to stall and
// release the register file ports while a command is running.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | waiting for a command, cmd_ready high
// DUMP_RD   | read register at addr, capture it into out_data
// DUMP_HOLD | present out_data until the consumer takes it
// LOAD      | write each accepted input byte to register at addr
module reg_file_debug_port #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_op,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [ADDR_W-1:0] cmd_cnt,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] rf_ra,
    input  logic [DATA_W-1:0] rf_rd,
    output logic [ADDR_W-1:0] rf_wa,
    output logic [DATA_W-1:0] rf_wd,
    output logic              rf_we,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        DUMP_RD   = 2'd1,
        DUMP_HOLD = 2'd2,
        LOAD      = 2'd3
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] rem;   // registers still to move after the current one
    logic              last;

    assign last = (rem == '0);

    // Command sequencer: walks addr upward (wrapping) while rem counts down.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            addr      <= '0;
            rem       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        addr  <= cmd_addr;
                        rem   <= cmd_cnt;
                        state <= cmd_op ? LOAD : DUMP_RD;
                    end
                end
                DUMP_RD: begin
                    out_data  <= rf_rd;
                    out_valid <= 1'b1;
                    state     <= DUMP_HOLD;
                end
                DUMP_HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (last) begin
                            done  <= 1'b1;
                            state <= IDLE;
                        end else begin
                            addr  <= addr + 1'b1;
                            rem   <= rem - 1'b1;
                            state <= DUMP_RD;
                        end
                    end
                end
                LOAD: begin
                    if (in_valid) begin
                        if (last) begin
                            done  <= 1'b1;
                            state <= IDLE;
                        end else begin
                            addr <= addr + 1'b1;
                            rem  <= rem - 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Port-facing strobes are decoded from state so the core sees zeros
    // on the register file ports whenever this block is not using them.
    always_comb begin
        cmd_ready = (state == IDLE);
        busy      = (state != IDLE);
        in_ready  = (state == LOAD);
        rf_we     = 1'b0;
        rf_wa     = '0;
        rf_wd     = '0;
        rf_ra     = '0;
        if (state == LOAD) begin
            rf_we = in_valid;
            rf_wa = addr;
            rf_wd = in_data;
        end
        if (state == DUMP_RD) begin
            rf_ra = addr;
        end
    end

endmodule

// File: tb/tb_reg_file_debug_port.sv
// Bench for reg_file_debug_port: a behavioural register file, a write log,
// a table of directed LOAD/DUMP commands and hand sequences for stalls,
// back-to-back commands, random LOAD pacing and reset mid-command.
module tb_reg_file_debug_port;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid, cmd_ready, cmd_op;
    logic [3:0] cmd_addr, cmd_cnt;
    logic       in_valid, in_ready;
    logic [7:0] in_data;
    logic       out_valid, out_ready;
    logic [7:0] out_data;
    logic [3:0] rf_ra, rf_wa;
    logic [7:0] rf_rd, rf_wd;
    logic       rf_we, busy, done;

    always #5 clk = ~clk;

    reg_file_debug_port #(.DATA_W(8), .ADDR_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_addr(cmd_addr), .cmd_cnt(cmd_cnt),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .rf_ra(rf_ra), .rf_rd(rf_rd), .rf_wa(rf_wa), .rf_wd(rf_wd),
        .rf_we(rf_we), .busy(busy), .done(done)
    );

    typedef struct {
        logic [3:0] a;
        logic [7:0] d;
    } wr_t;

    logic [7:0] rf [16];
    wr_t        wlog [$];
    int         bad_we = 0;
    int         checks = 0;
    int         failures = 0;

    assign rf_rd = rf[rf_ra];

    always @(posedge clk) begin
        if (rf_we) begin
            rf[rf_wa] <= rf_wd;
            wlog.push_back('{rf_wa, rf_wd});
            if (!in_valid) bad_we++;
        end
    end

    typedef struct {
        logic            op;
        logic [3:0]      addr;
        logic [3:0]      cnt;
        logic [3:0][7:0] b;    // bytes to load or bytes expected from a dump
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue_cmd(input logic op, input logic [3:0] a, input logic [3:0] c);
        int n = 0;
        cmd_op = op; cmd_addr = a; cmd_cnt = c; cmd_valid = 1'b1;
        #1;
        while (!cmd_ready && n < 100) begin
            tick();
            n++;
        end
        if (!cmd_ready) chk("cmd_ready_timeout", 32'(cmd_ready), 32'd1);
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic run_load(input logic [3:0] a, input logic [3:0] c, input logic [3:0][7:0] b);
        int base = wlog.size();
        logic [3:0] wa;
        issue_cmd(1'b1, a, c);
        for (int i = 0; i <= int'(c); i++) begin
            in_valid = 1'b1;
            in_data  = b[i];
            wa       = a + 4'(i);
            #1;
            chk("load_in_ready", 32'(in_ready), 32'd1);
            chk("load_rf_we", 32'(rf_we), 32'd1);
            chk("load_rf_wa", 32'(rf_wa), 32'(wa));
            chk("load_busy", 32'(busy), 32'd1);
            tick();
        end
        in_valid = 1'b0;
        chk("load_done", 32'(done), 32'd1);
        chk("load_busy_after", 32'(busy), 32'd0);
        chk("load_write_count", 32'(wlog.size() - base), 32'(int'(c) + 1));
        for (int i = 0; i <= int'(c) && base + i < wlog.size(); i++) begin
            wa = a + 4'(i);
            chk("load_log_addr", 32'(wlog[base + i].a), 32'(wa));
            chk("load_log_data", 32'(wlog[base + i].d), 32'(b[i]));
        end
    endtask

    task automatic wait_out_valid();
        int n = 0;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
        chk("out_valid_seen", 32'(out_valid), 32'd1);
    endtask

    task automatic run_dump(input logic [3:0] a, input logic [3:0] c, input logic [3:0][7:0] b);
        issue_cmd(1'b0, a, c);
        out_ready = 1'b1;
        for (int i = 0; i <= int'(c); i++) begin
            wait_out_valid();
            chk("dump_data", 32'(out_data), 32'(b[i]));
            tick();
        end
        chk("dump_done", 32'(done), 32'd1);
        chk("dump_out_valid_after", 32'(out_valid), 32'd0);
        chk("dump_busy_after", 32'(busy), 32'd0);
        out_ready = 1'b0;
    endtask

    vec_t vecs [7];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, sent, cyc;
        logic v;
        logic [3:0] wa;

        vecs[0] = '{1'b1, 4'd3,  4'd2, {8'h00, 8'hC3, 8'hB2, 8'hA1}};
        vecs[1] = '{1'b0, 4'd3,  4'd2, {8'h00, 8'hC3, 8'hB2, 8'hA1}};
        vecs[2] = '{1'b1, 4'd14, 4'd3, {8'h01, 8'h00, 8'h0F, 8'h0E}};
        vecs[3] = '{1'b0, 4'd14, 4'd3, {8'h01, 8'h00, 8'h0F, 8'h0E}};
        vecs[4] = '{1'b1, 4'd7,  4'd0, {8'h00, 8'h00, 8'h00, 8'h5A}};
        vecs[5] = '{1'b0, 4'd7,  4'd0, {8'h00, 8'h00, 8'h00, 8'h5A}};
        vecs[6] = '{1'b0, 4'd4,  4'd0, {8'h00, 8'h00, 8'h00, 8'hB2}};

        for (int i = 0; i < 16; i++) rf[i] = 8'h00;
        rst_n = 1'b0;
        cmd_valid = 1'b0; cmd_op = 1'b0; cmd_addr = '0; cmd_cnt = '0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        #1;
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_rf_we", 32'(rf_we), 32'd0);
        @(posedge clk); @(posedge clk);
        #3 rst_n = 1'b1;
        tick();

        // Directed command table
        foreach (vecs[k]) begin
            if (vecs[k].op) run_load(vecs[k].addr, vecs[k].cnt, vecs[k].b);
            else            run_dump(vecs[k].addr, vecs[k].cnt, vecs[k].b);
            tick();
        end

        // DUMP with consumer stalled for 5 cycles (R3=A1, R4=B2)
        issue_cmd(1'b0, 4'd3, 4'd1);
        out_ready = 1'b0;
        wait_out_valid();
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall_out_valid", 32'(out_valid), 32'd1);
            chk("stall_out_data", 32'(out_data), 32'hA1);
        end
        out_ready = 1'b1;
        tick();
        chk("stall_consumed_once", 32'(out_valid), 32'd0);
        chk("stall_not_done", 32'(done), 32'd0);
        wait_out_valid();
        chk("stall_second_byte", 32'(out_data), 32'hB2);
        tick();
        chk("stall_done", 32'(done), 32'd1);
        out_ready = 1'b0;
        tick();

        // Back-to-back: DUMP held during the done cycle of a LOAD
        cmd_valid = 1'b1; cmd_op = 1'b1; cmd_addr = 4'd8; cmd_cnt = 4'd0;
        #1;
        chk("b2b_first_ready", 32'(cmd_ready), 32'd1);
        tick();
        cmd_op = 1'b0; cmd_addr = 4'd8; cmd_cnt = 4'd0;
        in_valid = 1'b1; in_data = 8'h77;
        #1;
        chk("b2b_busy_ready", 32'(cmd_ready), 32'd0);
        tick();
        in_valid = 1'b0;
        chk("b2b_done", 32'(done), 32'd1);
        chk("b2b_ready_in_done", 32'(cmd_ready), 32'd1);
        tick();
        cmd_valid = 1'b0;
        chk("b2b_no_gap_busy", 32'(busy), 32'd1);
        tick();
        chk("b2b_dump_valid", 32'(out_valid), 32'd1);
        chk("b2b_dump_data", 32'(out_data), 32'h77);
        out_ready = 1'b1;
        tick();
        chk("b2b_dump_done", 32'(done), 32'd1);
        out_ready = 1'b0;
        tick();

        // Full 16-register LOAD from addr 5 with random input pacing
        base = wlog.size();
        issue_cmd(1'b1, 4'd5, 4'd15);
        sent = 0; cyc = 0;
        while (sent < 16 && cyc < 300) begin
            v = 1'($urandom_range(0, 1));
            in_valid = v;
            in_data  = v ? (8'h10 + 8'(sent)) : 8'($urandom);
            #1;
            if (v) sent++;
            tick();
            cyc++;
        end
        in_valid = 1'b0;
        chk("rand_all_sent", 32'(sent), 32'd16);
        chk("rand_done", 32'(done), 32'd1);
        chk("rand_write_count", 32'(wlog.size() - base), 32'd16);
        for (int i = 0; i < 16 && base + i < wlog.size(); i++) begin
            wa = 4'd5 + 4'(i);
            chk("rand_log_addr", 32'(wlog[base + i].a), 32'(wa));
            chk("rand_log_data", 32'(wlog[base + i].d), 32'(8'h10 + 8'(i)));
        end
        tick();

        // Reset in the middle of a LOAD with a byte still offered
        base = wlog.size();
        issue_cmd(1'b1, 4'd0, 4'd5);
        in_valid = 1'b1; in_data = 8'h31;
        tick();
        in_data = 8'h32;
        tick();
        in_data = 8'h33;
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_rf_we", 32'(rf_we), 32'd0);
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_done", 32'(done), 32'd0);
        chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk); @(posedge clk);
        #3 rst_n = 1'b1;
        tick(); tick(); tick();
        chk("post_rst_done", 32'(done), 32'd0);
        chk("post_rst_busy", 32'(busy), 32'd0);
        in_valid = 1'b0;
        chk("post_rst_write_count", 32'(wlog.size() - base), 32'd2);
        chk("post_rst_r0_kept", 32'(rf[0]), 32'h31);
        chk("post_rst_r1_kept", 32'(rf[1]), 32'h32);

        chk("we_without_valid", 32'(bad_we), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
